// File: rtl/fp_div_seq.sv
// fp_div_seq: sequential single-precision divider, fp_Z = fp_X / fp_Y.
// Radix-2 restoring quotient loop, one quotient bit per clock.
// Subnormal operands are flushed to zero. Underflowing results are also
// flushed to zero. Rounding mode encoding matches the ALU multiply unit.
module fp_div_seq (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [31:0] fp_X,
  input  logic [31:0] fp_Y,
  input  logic [2:0]  r_mode,
  output logic        busy,
  output logic        done,
  output logic [31:0] fp_Z,
  output logic        ovrf,
  output logic        udrf,
  output logic        dz
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_ITER  = 3'd2,
    S_ROUND = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  localparam logic [4:0] LAST_ITER = 5'd26;

  state_t             state_q, state_d;
  logic [31:0]        x_q, x_d;
  logic [31:0]        y_q, y_d;
  logic [2:0]         rm_q, rm_d;
  logic               sign_q, sign_d;
  logic [24:0]        r_q, r_d;
  logic [26:0]        quo_q, quo_d;
  logic signed [9:0]  e_q, e_d;
  logic [4:0]         cnt_q, cnt_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic [31:0]        fp_z_q, fp_z_d;
  logic               ovrf_q, ovrf_d;
  logic               udrf_q, udrf_d;
  logic               dz_q, dz_d;

  // Operand classification and quotient-step signals.
  logic        accept_s;
  logic        sign_s;
  logic        x_zero_s, x_inf_s, x_nan_s;
  logic        y_zero_s, y_inf_s, y_nan_s;
  logic [24:0] divisor_s;
  logic [24:0] diff_s;
  logic        ge_s;
  logic [24:0] r_sub_s;

  // Normalise / round path signals.
  logic [22:0]       frac_s;
  logic              g_s, s_s;
  logic signed [9:0] e_norm_s;
  logic              inc_s;
  logic [23:0]       frac_inc_s;
  logic signed [9:0] e_rnd_s;
  logic              ovf_s, udf_s;
  logic [31:0]       ovf_res_s;
  logic [31:0]       result_s;

  // A new request is only taken while no operation is running.
  assign accept_s = start & ~busy_q;
  assign sign_s   = x_q[31] ^ y_q[31];

  // Exponent field 0 is zero (subnormals flushed), 255 is inf/NaN.
  assign x_zero_s = (x_q[30:23] == 8'd0);
  assign x_inf_s  = (x_q[30:23] == 8'hFF) & (x_q[22:0] == 23'd0);
  assign x_nan_s  = (x_q[30:23] == 8'hFF) & (x_q[22:0] != 23'd0);
  assign y_zero_s = (y_q[30:23] == 8'd0);
  assign y_inf_s  = (y_q[30:23] == 8'hFF) & (y_q[22:0] == 23'd0);
  assign y_nan_s  = (y_q[30:23] == 8'hFF) & (y_q[22:0] != 23'd0);

  // Restoring step: subtract the divisor when the remainder covers it.
  assign divisor_s = {2'b01, y_q[22:0]};
  assign diff_s    = r_q - divisor_s;
  assign ge_s      = (r_q >= divisor_s);
  assign r_sub_s   = ge_s ? diff_s : r_q;

  // Normalise the quotient, pick the rounding increment, build the result.
  always_comb begin
    frac_s     = 23'd0;
    g_s        = 1'b0;
    s_s        = 1'b0;
    e_norm_s   = e_q;
    inc_s      = 1'b0;
    frac_inc_s = 24'd0;
    e_rnd_s    = e_q;
    ovf_s      = 1'b0;
    udf_s      = 1'b0;
    ovf_res_s  = 32'd0;
    result_s   = 32'd0;

    // Quotient lies in [0.5, 2): the leading one is at bit 26 or bit 25.
    if (quo_q[26]) begin
      frac_s   = quo_q[25:3];
      g_s      = quo_q[2];
      s_s      = (quo_q[1:0] != 2'd0) | (r_q != 25'd0);
      e_norm_s = e_q;
    end else begin
      frac_s   = quo_q[24:2];
      g_s      = quo_q[1];
      s_s      = quo_q[0] | (r_q != 25'd0);
      e_norm_s = e_q - 10'sd1;
    end

    case (rm_q)
      3'b000:  inc_s = g_s & (s_s | frac_s[0]);
      3'b001:  inc_s = 1'b0;
      3'b010:  inc_s = sign_q & (g_s | s_s);
      3'b011:  inc_s = ~sign_q & (g_s | s_s);
      3'b100:  inc_s = g_s;
      default: inc_s = g_s & (s_s | frac_s[0]);
    endcase

    // A carry out of the fraction means the mantissa became 10.0: the
    // fraction wraps to zero (1.0) and the exponent steps up.
    frac_inc_s = {1'b0, frac_s} + {23'd0, inc_s};
    if (frac_inc_s[23]) begin
      e_rnd_s = e_norm_s + 10'sd1;
    end else begin
      e_rnd_s = e_norm_s;
    end

    ovf_s = (e_rnd_s >= 10'sd255);
    udf_s = (e_rnd_s <= 10'sd0);

    case (rm_q)
      3'b001:  ovf_res_s = {sign_q, 31'h7F7FFFFF};
      3'b010:  ovf_res_s = sign_q ? 32'hFF800000 : 32'h7F7FFFFF;
      3'b011:  ovf_res_s = sign_q ? 32'hFF7FFFFF : 32'h7F800000;
      default: ovf_res_s = {sign_q, 31'h7F800000};
    endcase

    if (ovf_s) begin
      result_s = ovf_res_s;
    end else if (udf_s) begin
      result_s = {sign_q, 31'd0};
    end else begin
      result_s = {sign_q, e_rnd_s[7:0], frac_inc_s[22:0]};
    end
  end

  // Next-state logic for the controller and all datapath registers.
  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    y_d     = y_q;
    rm_d    = rm_q;
    sign_d  = sign_q;
    r_d     = r_q;
    quo_d   = quo_q;
    e_d     = e_q;
    cnt_d   = cnt_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    fp_z_d  = fp_z_q;
    ovrf_d  = ovrf_q;
    udrf_d  = udrf_q;
    dz_d    = dz_q;

    case (state_q)
      // DONE also accepts a start so back-to-back requests lose no cycle.
      S_IDLE, S_DONE: begin
        if (accept_s) begin
          x_d     = fp_X;
          y_d     = fp_Y;
          rm_d    = r_mode;
          ovrf_d  = 1'b0;
          udrf_d  = 1'b0;
          dz_d    = 1'b0;
          busy_d  = 1'b1;
          state_d = S_LOAD;
        end else begin
          state_d = S_IDLE;
        end
      end

      S_LOAD: begin
        sign_d = sign_s;
        if (x_nan_s | y_nan_s | (x_zero_s & y_zero_s) | (x_inf_s & y_inf_s)) begin
          fp_z_d  = 32'h7FC00000;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          state_d = S_DONE;
        end else if (x_inf_s) begin
          fp_z_d  = {sign_s, 31'h7F800000};
          busy_d  = 1'b0;
          done_d  = 1'b1;
          state_d = S_DONE;
        end else if (y_inf_s | x_zero_s) begin
          fp_z_d  = {sign_s, 31'd0};
          busy_d  = 1'b0;
          done_d  = 1'b1;
          state_d = S_DONE;
        end else if (y_zero_s) begin
          fp_z_d  = {sign_s, 31'h7F800000};
          dz_d    = 1'b1;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          state_d = S_DONE;
        end else begin
          r_d     = {2'b01, x_q[22:0]};
          quo_d   = 27'd0;
          e_d     = $signed({2'b00, x_q[30:23]}) - $signed({2'b00, y_q[30:23]}) + 10'sd127;
          cnt_d   = 5'd0;
          state_d = S_ITER;
        end
      end

      S_ITER: begin
        quo_d = {quo_q[25:0], ge_s};
        r_d   = r_sub_s << 1;
        cnt_d = cnt_q + 5'd1;
        if (cnt_q == LAST_ITER) begin
          state_d = S_ROUND;
        end else begin
          state_d = S_ITER;
        end
      end

      S_ROUND: begin
        fp_z_d  = result_s;
        ovrf_d  = ovf_s;
        udrf_d  = ~ovf_s & udf_s;
        busy_d  = 1'b0;
        done_d  = 1'b1;
        state_d = S_DONE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and output registers; reset aborts any operation in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      x_q     <= 32'd0;
      y_q     <= 32'd0;
      rm_q    <= 3'd0;
      sign_q  <= 1'b0;
      r_q     <= 25'd0;
      quo_q   <= 27'd0;
      e_q     <= 10'sd0;
      cnt_q   <= 5'd0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      fp_z_q  <= 32'd0;
      ovrf_q  <= 1'b0;
      udrf_q  <= 1'b0;
      dz_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      y_q     <= y_d;
      rm_q    <= rm_d;
      sign_q  <= sign_d;
      r_q     <= r_d;
      quo_q   <= quo_d;
      e_q     <= e_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      fp_z_q  <= fp_z_d;
      ovrf_q  <= ovrf_d;
      udrf_q  <= udrf_d;
      dz_q    <= dz_d;
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign fp_Z = fp_z_q;
  assign ovrf = ovrf_q;
  assign udrf = udrf_q;
  assign dz   = dz_q;

endmodule

// File: tb/tb_fp_div_seq.sv
// Directed self-checking bench for fp_div_seq with hand-computed quotients.
module tb_fp_div_seq;

  logic        clk;
  logic        rst;
  logic        start;
  logic [31:0] fp_X;
  logic [31:0] fp_Y;
  logic [2:0]  r_mode;
  logic        busy;
  logic        done;
  logic [31:0] fp_Z;
  logic        ovrf;
  logic        udrf;
  logic        dz;

  int checks   = 0;
  int failures = 0;
  int lat      = 0;

  fp_div_seq dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .fp_X   (fp_X),
    .fp_Y   (fp_Y),
    .r_mode (r_mode),
    .busy   (busy),
    .done   (done),
    .fp_Z   (fp_Z),
    .ovrf   (ovrf),
    .udrf   (udrf),
    .dz     (dz)
  );

  // 10 ns clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance one clock and sample 1 ns after the edge.
  task automatic step();
    @(posedge clk);
    #1;
    lat++;
  endtask

  // Present a request for one edge, then scramble the inputs.
  task automatic issue(input logic [31:0] x, input logic [31:0] y, input logic [2:0] rm);
    start  = 1'b1;
    fp_X   = x;
    fp_Y   = y;
    r_mode = rm;
    @(posedge clk);
    #1;
    start  = 1'b0;
    fp_X   = 32'hDEADBEEF;
    fp_Y   = 32'h12345678;
    r_mode = 3'b011;
    lat    = 1;
  endtask

  task automatic wait_done(input string tag);
    while (!done && lat < 60) step();
    check_val({tag, "_done_seen"}, 32'(done), 32'd1);
  endtask

  task automatic run_vec(input string tag, input logic [31:0] x, input logic [31:0] y,
                         input logic [2:0] rm, input logic [31:0] z, input logic [2:0] flags,
                         input int exp_lat);
    issue(x, y, rm);
    check_val({tag, "_busy"}, 32'(busy), 32'd1);
    check_val({tag, "_flags_clr"}, 32'({ovrf, udrf, dz}), 32'd0);
    wait_done(tag);
    check_val({tag, "_lat"}, 32'(lat), 32'(exp_lat));
    check_val({tag, "_z"}, fp_Z, z);
    check_val({tag, "_flags"}, 32'({ovrf, udrf, dz}), 32'(flags));
    check_val({tag, "_busy_done"}, 32'(busy), 32'd0);
    step();
    check_val({tag, "_pulse"}, 32'(done), 32'd0);
    check_val({tag, "_hold"}, fp_Z, z);
  endtask

  int done_seen;

  initial begin
    rst    = 1'b1;
    start  = 1'b0;
    fp_X   = 32'd0;
    fp_Y   = 32'd0;
    r_mode = 3'd0;
    step();
    step();
    rst = 1'b0;
    step();
    check_val("reset_outs", {busy, done, ovrf, udrf, dz, 27'd0}, 32'd0);
    check_val("reset_z", fp_Z, 32'd0);

    // flags are {ovrf, udrf, dz}
    run_vec("div6_2",      32'h40C00000, 32'h40000000, 3'd0, 32'h40400000, 3'b000, 30);
    run_vec("third_rne",   32'h3F800000, 32'h40400000, 3'd0, 32'h3EAAAAAB, 3'b000, 30);
    run_vec("third_rtz",   32'h3F800000, 32'h40400000, 3'd1, 32'h3EAAAAAA, 3'b000, 30);
    run_vec("third_rdn",   32'h3F800000, 32'h40400000, 3'd2, 32'h3EAAAAAA, 3'b000, 30);
    run_vec("third_rup",   32'h3F800000, 32'h40400000, 3'd3, 32'h3EAAAAAB, 3'b000, 30);
    run_vec("third_rmm",   32'h3F800000, 32'h40400000, 3'd4, 32'h3EAAAAAB, 3'b000, 30);
    run_vec("third_m7",    32'h3F800000, 32'h40400000, 3'd7, 32'h3EAAAAAB, 3'b000, 30);
    run_vec("nthird_rdn",  32'hBF800000, 32'h40400000, 3'd2, 32'hBEAAAAAB, 3'b000, 30);
    run_vec("nthird_rup",  32'hBF800000, 32'h40400000, 3'd3, 32'hBEAAAAAA, 3'b000, 30);
    run_vec("div_zero",    32'h3F800000, 32'h00000000, 3'd0, 32'h7F800000, 3'b001, 2);
    run_vec("zero_zero",   32'h00000000, 32'h00000000, 3'd0, 32'h7FC00000, 3'b000, 2);
    run_vec("nzero_2",     32'h80000000, 32'h40000000, 3'd0, 32'h80000000, 3'b000, 2);
    run_vec("nan_x",       32'h7FC00001, 32'h40000000, 3'd0, 32'h7FC00000, 3'b000, 2);
    run_vec("inf_inf",     32'h7F800000, 32'hFF800000, 3'd0, 32'h7FC00000, 3'b000, 2);
    run_vec("inf_x",       32'h7F800000, 32'hC0000000, 3'd0, 32'hFF800000, 3'b000, 2);
    run_vec("x_inf",       32'h40000000, 32'h7F800000, 3'd0, 32'h00000000, 3'b000, 2);
    run_vec("ovf_rne",     32'h7F000000, 32'h3E800000, 3'd0, 32'h7F800000, 3'b100, 30);
    run_vec("ovf_rtz",     32'h7F000000, 32'h3E800000, 3'd1, 32'h7F7FFFFF, 3'b100, 30);
    run_vec("ovf_rdn",     32'h7F000000, 32'h3E800000, 3'd2, 32'h7F7FFFFF, 3'b100, 30);
    run_vec("ovf_rup",     32'h7F000000, 32'h3E800000, 3'd3, 32'h7F800000, 3'b100, 30);
    run_vec("novf_rdn",    32'hFF000000, 32'h3E800000, 3'd2, 32'hFF800000, 3'b100, 30);
    run_vec("novf_rup",    32'hFF000000, 32'h3E800000, 3'd3, 32'hFF7FFFFF, 3'b100, 30);
    run_vec("udf",         32'h00800001, 32'h40000000, 3'd0, 32'h00000000, 3'b010, 30);
    run_vec("subn_x",      32'h00400000, 32'h3F800000, 3'd0, 32'h00000000, 3'b000, 2);

    // start while busy is ignored
    issue(32'h40C00000, 32'h40000000, 3'd0);
    step();
    step();
    step();
    start = 1'b1;
    fp_X  = 32'h3F800000;
    fp_Y  = 32'h40400000;
    step();
    start = 1'b0;
    wait_done("busy_ign");
    check_val("busy_ign_lat", 32'(lat), 32'd30);
    check_val("busy_ign_z", fp_Z, 32'h40400000);
    step();
    step();
    check_val("busy_ign_no2nd", 32'({busy, done}), 32'd0);

    // back-to-back: start in the done cycle
    issue(32'h3F800000, 32'h40400000, 3'd0);
    wait_done("b2b_a");
    check_val("b2b_a_z", fp_Z, 32'h3EAAAAAB);
    issue(32'h40C00000, 32'h40000000, 3'd0);
    wait_done("b2b_b");
    check_val("b2b_b_lat", 32'(lat), 32'd30);
    check_val("b2b_b_z", fp_Z, 32'h40400000);
    step();

    // reset during ITER cycle 10 aborts with no done
    issue(32'h7F000000, 32'h3E800000, 3'd0);
    while (lat < 11) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    check_val("rst_outs", {busy, done, ovrf, udrf, dz, 27'd0}, 32'd0);
    check_val("rst_z", fp_Z, 32'd0);
    done_seen = 0;
    for (int i = 0; i < 40; i++) begin
      step();
      if (done) done_seen++;
    end
    check_val("rst_no_done", 32'(done_seen), 32'd0);

    // simultaneous rst and start: rst wins
    rst    = 1'b1;
    start  = 1'b1;
    fp_X   = 32'h40C00000;
    fp_Y   = 32'h40000000;
    step();
    rst   = 1'b0;
    start = 1'b0;
    check_val("rst_start_busy", 32'(busy), 32'd0);
    step();
    step();
    check_val("rst_start_idle", 32'({busy, done}), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
